// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-arbiter widths, ID constants and types.
package axi_rd_arbiter_pkg;
   localparam int A_ID_WID    = 4;
   localparam int A_LEN_WID   = 8;
   localparam int A_SIZE_WID  = 3;
   localparam int A_BURST_WID = 2;
   localparam int A_LOCK_WID  = 2;
   localparam int A_CACHE_WID = 4;
   localparam int A_PROT_WID  = 3;

   localparam logic [A_ID_WID-1:0] ID_INST = 4'd0;
   localparam logic [A_ID_WID-1:0] ID_DATA = 4'd1;

   typedef enum logic {IDLE, AR_WAIT} ar_state_e;

   typedef struct packed {
      logic [A_ID_WID-1:0]   id;
      logic [31:0]           addr;
      logic [A_SIZE_WID-1:0] size;
   } ar_req_t;
endpackage

// File: rtl/axi_rd_arbiter_outs_cnt.sv
// Per-ID outstanding-read counter; simultaneous inc and dec cancel out.
module rd_outs_cnt #(
   parameter int MAX_OUTS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic       full,
   output logic [1:0] count
);
   assign full = (count == 2'(MAX_OUTS));

   // The caller gates dec with count != 0 and inc with !full.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && !dec)
         count <= count + 2'd1;
      else if (dec && !inc)
         count <= count - 2'd1;
   end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction/data read requests onto one AXI AR/R channel pair.
// Build option: define AXI_RR_ARB_EN for round-robin, otherwise data has fixed priority.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int MAX_OUTS = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inst_req,
   input  logic [31:0]            inst_addr,
   input  logic [1:0]             inst_size,
   output logic                   inst_addr_ok,
   output logic                   inst_data_ok,
   output logic [31:0]            inst_rdata,
   input  logic                   data_req,
   input  logic [31:0]            data_addr,
   input  logic [1:0]             data_size,
   output logic                   data_addr_ok,
   output logic                   data_data_ok,
   output logic [31:0]            data_rdata,
   output logic [A_ID_WID-1:0]    arid,
   output logic [31:0]            araddr,
   output logic [A_LEN_WID-1:0]   arlen,
   output logic [A_SIZE_WID-1:0]  arsize,
   output logic [A_BURST_WID-1:0] arburst,
   output logic [A_LOCK_WID-1:0]  arlock,
   output logic [A_CACHE_WID-1:0] arcache,
   output logic [A_PROT_WID-1:0]  arprot,
   output logic                   arvalid,
   input  logic                   arready,
   input  logic [A_ID_WID-1:0]    rid,
   input  logic [31:0]            rdata,
   input  logic                   rvalid,
   output logic                   rready
);
   ar_state_e  state;
   ar_req_t    ar_q;
   logic       inst_full, data_full;
   logic [1:0] inst_cnt, data_cnt;
   logic       inst_elig, data_elig, gnt_inst, gnt_data, idle;
   logic       ar_hs, r_hs;

   assign inst_elig = inst_req & ~inst_full;
   assign data_elig = data_req & ~data_full;

`ifdef AXI_RR_ARB_EN
   logic last_data;
   // On contention the requester that did not win last time goes first.
   assign gnt_data = data_elig & (~inst_elig | ~last_data);
   assign gnt_inst = inst_elig & (~data_elig |  last_data);
`else
   assign gnt_data = data_elig;
   assign gnt_inst = inst_elig & ~data_elig;
`endif

   assign idle         = (state == IDLE) & ~reset;
   assign inst_addr_ok = idle & gnt_inst;
   assign data_addr_ok = idle & gnt_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         arvalid <= 1'b0;
         ar_q    <= '0;
`ifdef AXI_RR_ARB_EN
         last_data <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (gnt_inst | gnt_data) begin
               state     <= AR_WAIT;
               arvalid   <= 1'b1;
               ar_q.id   <= gnt_data ? ID_DATA : ID_INST;
               ar_q.addr <= gnt_data ? data_addr : inst_addr;
               ar_q.size <= {1'b0, gnt_data ? data_size : inst_size};
`ifdef AXI_RR_ARB_EN
               last_data <= gnt_data;
`endif
            end
            AR_WAIT: if (arready) begin
               state   <= IDLE;
               arvalid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arid    = ar_q.id;
   assign araddr  = ar_q.addr;
   assign arsize  = ar_q.size;
   assign arlen   = '0;
   assign arburst = 2'b01;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;
   assign rready  = ~reset;

   assign ar_hs = arvalid & arready;
   assign r_hs  = rvalid & rready;

   // An R beat with nothing outstanding still returns data but is not counted.
   rd_outs_cnt #(.MAX_OUTS(MAX_OUTS)) u_inst_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ar_hs & (ar_q.id == ID_INST)),
      .dec   (r_hs & (rid == ID_INST) & (inst_cnt != 2'd0)),
      .full  (inst_full),
      .count (inst_cnt)
   );

   rd_outs_cnt #(.MAX_OUTS(MAX_OUTS)) u_data_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ar_hs & (ar_q.id == ID_DATA)),
      .dec   (r_hs & (rid == ID_DATA) & (data_cnt != 2'd0)),
      .full  (data_full),
      .count (data_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         inst_data_ok <= 1'b0;
         data_data_ok <= 1'b0;
         inst_rdata   <= '0;
         data_rdata   <= '0;
      end else begin
         inst_data_ok <= r_hs & (rid == ID_INST);
         data_data_ok <= r_hs & (rid == ID_DATA);
         if (r_hs && rid == ID_INST) inst_rdata <= rdata;
         if (r_hs && rid == ID_DATA) data_rdata <= rdata;
      end
   end
endmodule
